// File: rtl/t07_memory_responder_pkg.sv
// Shared types for the CPU memory responder: request encodings and FSM states.
package t07_pkg;

    typedef enum logic [1:0] {
        RWI_IDLE  = 2'b00,
        RWI_WRITE = 2'b01,
        RWI_READ  = 2'b10,
        RWI_FETCH = 2'b11
    } rwi_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_DONE = 2'b10
    } resp_state_t;

endpackage

// File: rtl/t07_memory_responder.sv
// Memory-side endpoint of the CPU memory-handler interface: turns each handler
// request into one single-beat classic bus cycle with a bounded ack wait.
//
// state  | meaning
// S_IDLE | waiting for rwi != 00; request captured on the accepting edge
// S_BUS  | cyc/stb asserted, waiting for ack or timeout
// S_DONE | one-cycle response: busy low, ExtData valid, err pulse on timeout
module t07_memory_responder
    import t07_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rwi,
    input  logic [ADDR_W-1:0] ExtAddress,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] ExtData,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dat_o,
    output logic [3:0]        mem_sel,
    output logic              mem_we,
    output logic              mem_cyc_stb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_dat_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    resp_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    rwi_t              req_rwi_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic [DATA_W-1:0] mem_dat_q;
    logic [DATA_W-1:0] ext_data_q;
    logic              err_q;
    logic              stb_q;
    logic              we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_rwi_q  <= RWI_IDLE;
            mem_adr_q  <= '0;
            mem_dat_q  <= '0;
            ext_data_q <= '0;
            err_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (rwi_t'(rwi) != RWI_IDLE) begin
                        req_rwi_q <= rwi_t'(rwi);
                        mem_adr_q <= ExtAddress & ~ADDR_W'(3);
                        mem_dat_q <= write_data;
                        cnt_q     <= '0;
                        stb_q     <= 1'b1;
                        we_q      <= (rwi_t'(rwi) == RWI_WRITE);
                        state_q   <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Ack is checked first so an ack on the last wait cycle still succeeds.
                    if (mem_ack) begin
                        if (req_rwi_q != RWI_WRITE) begin
                            ext_data_q <= mem_dat_i;
                        end
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        ext_data_q <= ERR_DATA;
                        err_q      <= 1'b1;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Freeze must rise in the request cycle itself, hence the combinational IDLE term.
    assign busy = !rst && (((state_q == S_IDLE) && (rwi != 2'b00)) || (state_q == S_BUS));

    assign ExtData     = ext_data_q;
    assign err         = err_q;
    assign mem_adr     = mem_adr_q;
    assign mem_dat_o   = mem_dat_q;
    assign mem_sel     = 4'hF;
    assign mem_we      = we_q;
    assign mem_cyc_stb = stb_q;

endmodule

// File: tb/tb_t07_memory_responder.sv
// Directed bench for t07_memory_responder: table of single transactions plus
// hand sequences for back-to-back requests, reset mid-cycle and stray acks.
module tb_t07_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rwi;
    logic [31:0] ExtAddress;
    logic [31:0] write_data;
    logic [31:0] ExtData;
    logic        busy;
    logic        err;
    logic [31:0] mem_adr;
    logic [31:0] mem_dat_o;
    logic [3:0]  mem_sel;
    logic        mem_we;
    logic        mem_cyc_stb;
    logic        mem_ack;
    logic [31:0] mem_dat_i;

    int n_checks = 0;
    int n_errors = 0;

    t07_memory_responder #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .rst(rst), .rwi(rwi), .ExtAddress(ExtAddress),
        .write_data(write_data), .ExtData(ExtData), .busy(busy), .err(err),
        .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_sel(mem_sel),
        .mem_we(mem_we), .mem_cyc_stb(mem_cyc_stb), .mem_ack(mem_ack),
        .mem_dat_i(mem_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rwi;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          nbus;
        bit          ack;
        logic [31:0] exp_adr;
        logic [31:0] exp_ext;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE just after an edge; leaves the DUT back in IDLE with rwi=00.
    task automatic run_txn(input vec_t v);
        rwi = v.rwi; ExtAddress = v.addr; write_data = v.wdata; mem_ack = 1'b0;
        #1;
        chk("busy_req", {31'd0, busy}, 32'd1);
        chk("stb_req", {31'd0, mem_cyc_stb}, 32'd0);
        tick();
        rwi = ~v.rwi;
        ExtAddress = 32'h5555_5555;
        write_data = 32'h0BAD_0BAD;
        for (int c = 0; c < v.nbus; c++) begin
            #1;
            chk("bus_stb", {31'd0, mem_cyc_stb}, 32'd1);
            chk("bus_busy", {31'd0, busy}, 32'd1);
            chk("bus_we", {31'd0, mem_we}, {31'd0, v.exp_we});
            chk("bus_adr", mem_adr, v.exp_adr);
            chk("bus_dat_o", mem_dat_o, v.wdata);
            chk("bus_sel", {28'd0, mem_sel}, 32'hF);
            if (c == v.nbus - 1 && v.ack) begin
                mem_ack = 1'b1;
                mem_dat_i = v.rdata;
            end
            tick();
            mem_ack = 1'b0;
            mem_dat_i = 32'hFFFF_0000;
        end
        rwi = v.rwi;
        #1;
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_stb", {31'd0, mem_cyc_stb}, 32'd0);
        chk("done_ext", ExtData, v.exp_ext);
        chk("done_err", {31'd0, err}, {31'd0, v.exp_err});
        tick();
        rwi = 2'b00;
        #1;
        chk("idle_err", {31'd0, err}, 32'd0);
        chk("idle_stb", {31'd0, mem_cyc_stb}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ext", ExtData, v.exp_ext);
    endtask

    initial begin
        //            rwi    addr          wdata         rdata         nbus ack  exp_adr       exp_ext       we    err
        vecs[0] = '{2'b10, 32'h0000_0006, 32'h0000_0000, 32'h1234_5678, 1, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 32'h0000_0100, 32'h8765_4321, 32'hAAAA_AAAA, 4, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 4, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[3] = '{2'b11, 32'h0000_0033, 32'h1111_1111, 32'hCAFE_F00D, 4, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 32'h0000_0044, 32'h0000_0001, 32'h7777_7777, 1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5, 2, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0, 1'b0};

        rst = 1'b1; rwi = 2'b10; ExtAddress = 32'h0; write_data = 32'h0;
        mem_ack = 1'b0; mem_dat_i = 32'h0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stb", {31'd0, mem_cyc_stb}, 32'd0);
        chk("rst_ext", ExtData, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_adr", mem_adr, 32'd0);
        rwi = 2'b00;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // rwi held at read through DONE: next bus cycle only after IDLE, 2-cycle stb gap
        rwi = 2'b10; ExtAddress = 32'h0000_0200; mem_dat_i = 32'h1357_9BDF;
        tick();
        chk("hold_bus_stb", {31'd0, mem_cyc_stb}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; mem_dat_i = 32'h2468_ACE0;
        chk("hold_done_stb", {31'd0, mem_cyc_stb}, 32'd0);
        chk("hold_done_busy", {31'd0, busy}, 32'd0);
        chk("hold_done_ext", ExtData, 32'h1357_9BDF);
        tick();
        chk("hold_idle_stb", {31'd0, mem_cyc_stb}, 32'd0);
        chk("hold_idle_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("hold_bus2_stb", {31'd0, mem_cyc_stb}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; rwi = 2'b00;
        chk("hold_done2_ext", ExtData, 32'h2468_ACE0);
        tick();

        // reset during BUS abandons the cycle; a late ack is then ignored
        rwi = 2'b10; ExtAddress = 32'h0000_0300;
        tick();
        chk("rbus_stb", {31'd0, mem_cyc_stb}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rbus_rst_stb", {31'd0, mem_cyc_stb}, 32'd0);
        chk("rbus_rst_busy", {31'd0, busy}, 32'd0);
        chk("rbus_rst_ext", ExtData, 32'd0);
        rst = 1'b0; rwi = 2'b00; mem_ack = 1'b1; mem_dat_i = 32'h9999_9999;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_stb", {31'd0, mem_cyc_stb}, 32'd0);
        chk("late_ack_ext", ExtData, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("late_ack_ext2", ExtData, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
